display_arbiter: RTL

DISPLAY_ARBITER -- requirements
Module: display_arbiter

---
 rtl/display_arbiter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/display_arbiter.sv
// Display ownership arbiter: ALU and temperature views share one 4-digit display,
// separated by a blank gap, with minimum-hold preemption and a force_temp test override.
module display_arbiter #(
    parameter int MIN_HOLD     = 1000,
    parameter int BLANK_CYCLES = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_alu,
    input  logic        req_temp,
    input  logic        force_temp,
    input  logic [19:0] alu_digits,
    input  logic [19:0] temp_digits,
    output logic        grant_alu,
    output logic        grant_temp,
    output logic [19:0] disp_digits,
    output logic [7:0]  handover_cnt
);

    localparam int HOLD_W  = $clog2(MIN_HOLD + 1);
    localparam int BLANK_W = $clog2(BLANK_CYCLES + 1);
    localparam logic [HOLD_W-1:0]  HOLD_MAX  = HOLD_W'(MIN_HOLD);
    localparam logic [BLANK_W-1:0] BLANK_END = BLANK_W'(BLANK_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_BLANK, S_OWN_ALU, S_OWN_TEMP} state_t;

    // Source encoding for tgt/last: 0 = ALU, 1 = TEMP.
    state_t              state_q, state_d;
    logic                tgt_q, tgt_d;
    logic                last_q, last_d;
    logic [BLANK_W-1:0]  blank_q, blank_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                grant_alu_q, grant_alu_d;
    logic                grant_temp_q, grant_temp_d;
    logic [19:0]         disp_q, disp_d;

    logic temp_act, eff_tgt, tgt_on, oth_on;
    logic [HOLD_W-1:0] hold_inc;

    assign temp_act = req_temp | force_temp;
    assign hold_inc = (hold_q == HOLD_MAX) ? hold_q : hold_q + HOLD_W'(1);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            tgt_q        <= 1'b0;
            last_q       <= 1'b1;
            blank_q      <= '0;
            hold_q       <= '0;
            cnt_q        <= 8'd0;
            grant_alu_q  <= 1'b0;
            grant_temp_q <= 1'b0;
            disp_q       <= 20'hFFFFF;
        end else begin
            state_q      <= state_d;
            tgt_q        <= tgt_d;
            last_q       <= last_d;
            blank_q      <= blank_d;
            hold_q       <= hold_d;
            cnt_q        <= cnt_d;
            grant_alu_q  <= grant_alu_d;
            grant_temp_q <= grant_temp_d;
            disp_q       <= disp_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        last_d  = last_q;
        blank_d = blank_q;
        hold_d  = hold_q;
        cnt_d   = cnt_q;
        // force_temp retargets a pending ALU gap without restarting its count
        eff_tgt = tgt_q | force_temp;
        tgt_on  = eff_tgt ? temp_act : req_alu;
        oth_on  = eff_tgt ? req_alu : temp_act;
        case (state_q)
            S_IDLE: begin
                blank_d = '0;
                if (req_alu || temp_act) begin
                    state_d = S_BLANK;
                    if (force_temp)               tgt_d = 1'b1;
                    else if (req_alu && req_temp) tgt_d = ~last_q;
                    else                          tgt_d = req_temp;
                end
            end
            S_BLANK: begin
                tgt_d = eff_tgt;
                if (blank_q == BLANK_END) begin
                    blank_d = '0;
                    if (tgt_on) begin
                        state_d = eff_tgt ? S_OWN_TEMP : S_OWN_ALU;
                        hold_d  = '0;
                        cnt_d   = cnt_q + 8'd1;
                        last_d  = eff_tgt;
                    end else if (oth_on) begin
                        tgt_d = ~eff_tgt;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    blank_d = blank_q + BLANK_W'(1);
                end
            end
            S_OWN_ALU: begin
                if (force_temp || (!req_alu && req_temp) ||
                    (req_alu && req_temp && hold_q == HOLD_MAX)) begin
                    state_d = S_BLANK;
                    tgt_d   = 1'b1;
                    blank_d = '0;
                end else if (!req_alu) begin
                    state_d = S_IDLE;
                end else begin
                    hold_d = hold_inc;
                end
            end
            S_OWN_TEMP: begin
                if ((!temp_act && req_alu) ||
                    (temp_act && !force_temp && req_alu && hold_q == HOLD_MAX)) begin
                    state_d = S_BLANK;
                    tgt_d   = 1'b0;
                    blank_d = '0;
                end else if (!temp_act) begin
                    state_d = S_IDLE;
                end else begin
                    hold_d = hold_inc;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        grant_alu_d  = (state_d == S_OWN_ALU);
        grant_temp_d = (state_d == S_OWN_TEMP);
        disp_d       = 20'hFFFFF;
        if (state_d == S_OWN_ALU)  disp_d = alu_digits;
        if (state_d == S_OWN_TEMP) disp_d = temp_digits;
    end

    assign grant_alu    = grant_alu_q;
    assign grant_temp   = grant_temp_q;
    assign disp_digits  = disp_q;
    assign handover_cnt = cnt_q;

endmodule
